// File: rtl/inv_mat_mul_serial.sv
// inv_mat_mul_serial
//   Sequential inverse of the nibble-wise GF(2) matrix layer. A 4x4 binary
//   matrix M is inverted by Gauss-Jordan elimination, one column per cycle.
//   M^-1 is then applied to each of the 16 nibbles of the latched state, one
//   nibble per cycle.
//
//   Matrix encoding: row k (output bit k) is matrix[4k+3:4k], and
//   M[k][j] = matrix[4k+j].
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   job request, sampled only in IDLE
//   in        in   64  state to decode, nibble i = in[4i+3:4i]
//   matrix    in   16  forward matrix
//   out       out  64  decoded state, x = M^-1 * y per nibble
//   busy      out  1   high during inversion and application
//   done      out  1   one-cycle completion pulse
//   singular  out  1   M not invertible; held until the next accepted start
module inv_mat_mul_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] in,
  input  logic [15:0] matrix,
  output logic [63:0] out,
  output logic        busy,
  output logic        done,
  output logic        singular
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INV  = 2'd1;
  localparam logic [1:0] S_APP  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]  state;
  logic [63:0] in_q;
  logic [15:0] a_q;      // working matrix, reduced toward identity
  logic [15:0] b_q;      // accumulator, ends as M^-1
  logic [1:0]  col;
  logic [3:0]  nib;
  logic        sing_q;

  // Elimination step for the current column
  logic        pivot_found;
  logic [1:0]  pivot;
  logic [3:0]  a_row [4];
  logic [3:0]  b_row [4];
  logic [3:0]  a_sw  [4];
  logic [3:0]  b_sw  [4];
  logic [15:0] a_nx;
  logic [15:0] b_nx;

  // Application step for the current nibble
  logic [3:0]  cur_nib;
  logic [3:0]  app_bits;

  always_comb begin
    pivot_found = 1'b0;
    pivot       = '0;
    a_nx        = '0;
    b_nx        = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      a_row[r] = a_q[4*r +: 4];
      b_row[r] = b_q[4*r +: 4];
    end

    // Lowest row at or below the diagonal with a one in this column
    for (int unsigned r = 0; r < 4; r++) begin
      if (!pivot_found && (r >= {30'd0, col}) && a_row[r][col]) begin
        pivot_found = 1'b1;
        pivot       = r[1:0];
      end
    end

    for (int unsigned r = 0; r < 4; r++) begin
      a_sw[r] = a_row[r];
      b_sw[r] = b_row[r];
    end
    a_sw[col]   = a_row[pivot];
    a_sw[pivot] = a_row[col];
    b_sw[col]   = b_row[pivot];
    b_sw[pivot] = b_row[col];

    // Clear this column in every other row using the (post-swap) pivot row
    for (int unsigned r = 0; r < 4; r++) begin
      if ((r[1:0] != col) && a_sw[r][col]) begin
        a_nx[4*r +: 4] = a_sw[r] ^ a_sw[col];
        b_nx[4*r +: 4] = b_sw[r] ^ b_sw[col];
      end else begin
        a_nx[4*r +: 4] = a_sw[r];
        b_nx[4*r +: 4] = b_sw[r];
      end
    end
  end

  always_comb begin
    cur_nib  = in_q[{nib, 2'b00} +: 4];
    app_bits = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      app_bits[k] = ^(cur_nib & b_q[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      in_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      col    <= '0;
      nib    <= '0;
      out    <= '0;
      sing_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            in_q   <= in;
            a_q    <= matrix;
            b_q    <= 16'h8421;
            out    <= '0;
            sing_q <= 1'b0;
            col    <= '0;
            state  <= S_INV;
          end
        end
        S_INV: begin
          if (!pivot_found) begin
            sing_q <= 1'b1;
            state  <= S_FIN;
          end else begin
            a_q <= a_nx;
            b_q <= b_nx;
            if (col == 2'd3) begin
              nib   <= '0;
              state <= S_APP;
            end else begin
              col <= col + 2'd1;
            end
          end
        end
        S_APP: begin
          out[{nib, 2'b00} +: 4] <= app_bits;
          if (nib == 4'd15) begin
            state <= S_FIN;
          end else begin
            nib <= nib + 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == S_INV) || (state == S_APP);
  assign done     = (state == S_FIN);
  assign singular = sing_q;

endmodule
